gol_engine: RTL and testbench
=============================

// Module: gol_engine
// PURPOSE
//  Sequential core of the 8x8 Game of Life datapath. Holds the 64-bit grid
//  register, loads a seed and advances one generation per tick. Runs free or
//  single-steps, and halts on a still life, an extinct grid or a generation
//  limit. Upstream: seed/control source (bench or switch/button front end).
//  Downstream: grid display and checker, which read grid/gen_count/flags.
// PARAMETERS
//  PERIOD   1     clocks per generation while running (>=1); 1 = every clock
//  MAX_GEN  1000  generation limit; reaching it halts with done=1
//  GEN_W    16    width of gen_count; MAX_GEN < 2**GEN_W
//  WRAP     0     0 = cells outside the grid are dead; 1 = toroidal wrap
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high
//  load       in   1      grid<=seed, clear counters/flags, go IDLE
//  seed       in   64     initial pattern; cell(r,c) = bit 8*r+c, r,c in 0..7
//  start      in   1      IDLE/HALT -> RUN
//  stop       in   1      RUN -> IDLE (pause; grid and gen_count kept)
//  step       in   1      in IDLE: advance exactly one generation
//  grid       out  64     current generation, same bit mapping as seed
//  gen_count  out  GEN_W  generations computed since last load/reset
//  running    out  1      1 while state==RUN
//  stable     out  1      sticky: last step produced next==grid
//  empty      out  1      sticky: grid is all zero after a step
//  done       out  1      sticky: gen_count reached MAX_GEN
// BEHAVIOUR
//  Reset (async): grid=0, gen_count=0, all flags=0, tick=0, state=IDLE.
//  Rules: live cell survives with 2 or 3 live neighbours; dead cell is born
//   with exactly 3; every other cell is dead in the next generation.
//   Neighbour count is 0..8 (4 bits). WRAP selects boundary handling.
//  FSM states: IDLE, RUN, HALT. Controls are sampled on rising clk edges.
//   Priority: load > stop > start > step.
//  load: in any state. One clock later, grid=seed and gen_count=0, flags
//   cleared, tick=0, state=IDLE.
//  IDLE: start -> RUN with tick=0. step -> one update this edge, stay IDLE.
//  RUN: tick counts 0..PERIOD-1. At PERIOD-1, perform an update and set
//   tick=0. stop -> IDLE with tick=0 and no update on that edge.
//  HALT: entered after an update that sets stable, empty or done.
//   start and step are ignored; only load or reset leaves HALT.
//  Update (one edge):
//   - grid <= next and gen_count <= gen_count+1.
//   - stable <= (next==grid); empty <= (next==0);
//     done <= (gen_count+1 == MAX_GEN).
//   - If any of these flags is set, go to HALT; otherwise stay in the
//     current state.
//   - Flags are computed from the pre-update grid.
//  Latency: grid holds generation N+1 one clock after the update edge.
//   running falls on the same edge that enters HALT.
//  Simultaneous: load with start ignores start. stop with step in RUN
//   goes to IDLE with no update.
//  gen_count never wraps, because HALT is forced at MAX_GEN.
//  Reset mid-RUN aborts immediately. No partial generation is ever visible.
// STRUCTURE
//  Package gol_pkg:
//   - localparams ROWS=8, COLS=8, CELLS=64
//   - typedef logic [63:0] grid_t
//   - typedef enum {IDLE, RUN, HALT} gol_state_t
//  Sub-module gol_next_state: purely combinational grid_t -> grid_t
//   evaluator with a WRAP parameter. gol_engine owns the registers, FSM,
//   tick counter and flags.
// TESTING
//  1. Blinker: load seed=64'h0000_0000_1C00_0000, step.
//     -> grid=64'h0000_0008_0808_0000, gen_count=1.
//     Step again -> grid back to the seed, gen_count=2, stable=0.
//  2. Block: load 64'h0000_0018_1800_0000, start.
//     -> after first update: grid unchanged, stable=1, HALT, gen_count=1.
//     Further start/step are ignored.
//  3. Lone cell: load 64'h0000_0000_0800_0000, step.
//     -> grid=0, empty=1, HALT, gen_count=1.
//  4. Limit: MAX_GEN=4, PERIOD=3, blinker seed, start.
//     -> updates occur every 3 clocks.
//     -> after the 4th update: done=1, grid=seed, gen_count=4, running=0.
//  5. Wrap: seed 64'h0000_0000_8300_0000, step.
//     -> WRAP=1: grid=64'h0000_0001_0101_0000.
//     -> WRAP=0: grid=0 with empty=1.
//  6. Control and reset:
//     -> stop during RUN freezes grid and gen_count.
//     -> load together with start leaves state IDLE.
//     -> reset asserted mid-RUN, between clock edges, immediately gives
//        grid=0, gen_count=0 and all flags 0.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and the neighbour-count helper for the 8x8 Game of Life core.
// Cell (r,c) lives at bit 8*r+c of a grid word.
package gol_pkg;

   localparam int unsigned ROWS  = 8;
   localparam int unsigned COLS  = 8;
   localparam int unsigned CELLS = ROWS * COLS;

   typedef logic [CELLS-1:0] grid_t;

   typedef enum logic [1:0] {IDLE, RUN, HALT} gol_state_t;

   // Offsets are biased by +ROWS/+COLS so all arithmetic stays unsigned.
   function automatic logic [3:0] neighbour_count(input grid_t g,
                                                  input int unsigned r,
                                                  input int unsigned c,
                                                  input logic wrap);
      logic [3:0]  n;
      int unsigned rr;
      int unsigned cc;
      n = '0;
      for (int unsigned dr = 0; dr < 3; dr++) begin
         for (int unsigned dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
               rr = r + dr + ROWS - 1;
               cc = c + dc + COLS - 1;
               if (wrap) begin
                  rr = rr % ROWS;
                  cc = cc % COLS;
                  n  = n + {3'b000, g[6'(rr * COLS + cc)]};
               end else if (rr >= ROWS && rr < 2 * ROWS && cc >= COLS && cc < 2 * COLS) begin
                  n = n + {3'b000, g[6'((rr - ROWS) * COLS + (cc - COLS))]};
               end
            end
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/gol_next_state.sv
// Combinational one-generation evaluator: grid in, next generation out.
// WRAP=0 treats off-grid cells as dead, WRAP=1 wraps toroidally.
module gol_next_state
   import gol_pkg::*;
#(
   parameter int unsigned WRAP = 0
) (
   input  logic [63:0] i_grid,
   output logic [63:0] o_next
);

   logic [3:0] w_n;

   always_comb begin
      o_next = '0;
      w_n    = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            w_n = neighbour_count(i_grid, r, c, WRAP != 0);
            o_next[6'(r * COLS + c)] = (w_n == 4'd3) ||
                                       (i_grid[6'(r * COLS + c)] && w_n == 4'd2);
         end
      end
   end

endmodule

// File: rtl/gol_engine.sv
// Sequential Game of Life core: grid register, IDLE/RUN/HALT control,
// generation pacing and the sticky stable/empty/done halt flags.
module gol_engine
   import gol_pkg::*;
#(
   parameter int unsigned PERIOD  = 1,
   parameter int unsigned MAX_GEN = 1000,
   parameter int unsigned GEN_W   = 16,
   parameter int unsigned WRAP    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [63:0]      seed,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   output logic [63:0]      grid,
   output logic [GEN_W-1:0] gen_count,
   output logic             running,
   output logic             stable,
   output logic             empty,
   output logic             done
);

   localparam int unsigned TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   gol_state_t        r_state;
   gol_state_t        w_state_nxt;
   logic [TICK_W-1:0] r_tick;
   logic [TICK_W-1:0] w_tick_nxt;
   grid_t             r_grid;
   grid_t             w_next;
   logic [GEN_W-1:0]  r_gen;
   logic [GEN_W-1:0]  w_gen_inc;
   logic              r_stable;
   logic              r_empty;
   logic              r_done;
   logic              w_upd;
   logic              w_stable;
   logic              w_empty;
   logic              w_done;

   gol_next_state #(.WRAP(WRAP)) u_next (
      .i_grid (r_grid),
      .o_next (w_next)
   );

   assign w_gen_inc = r_gen + 1'b1;
   assign w_stable  = (w_next == r_grid);
   assign w_empty   = (w_next == '0);
   assign w_done    = (w_gen_inc == GEN_W'(MAX_GEN));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_tick  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   // Priority load > stop > start > step; an update that raises any flag halts.
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_upd       = 1'b0;
      if (load) begin
         w_state_nxt = IDLE;
         w_tick_nxt  = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (stop) begin
                  w_state_nxt = IDLE;
               end else if (start) begin
                  w_state_nxt = RUN;
                  w_tick_nxt  = '0;
               end else if (step) begin
                  w_upd = 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  w_state_nxt = IDLE;
                  w_tick_nxt  = '0;
               end else if (r_tick == TICK_W'(PERIOD - 1)) begin
                  w_upd      = 1'b1;
                  w_tick_nxt = '0;
               end else begin
                  w_tick_nxt = r_tick + TICK_W'(1);
               end
            end
            HALT: w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
         endcase
         if (w_upd && (w_stable || w_empty || w_done)) begin
            w_state_nxt = HALT;
         end
      end
   end

   always_comb begin
      running   = (r_state == RUN);
      grid      = r_grid;
      gen_count = r_gen;
      stable    = r_stable;
      empty     = r_empty;
      done      = r_done;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grid   <= '0;
         r_gen    <= '0;
         r_stable <= 1'b0;
         r_empty  <= 1'b0;
         r_done   <= 1'b0;
      end else if (load) begin
         r_grid   <= seed;
         r_gen    <= '0;
         r_stable <= 1'b0;
         r_empty  <= 1'b0;
         r_done   <= 1'b0;
      end else if (w_upd) begin
         r_grid   <= w_next;
         r_gen    <= w_gen_inc;
         r_stable <= w_stable;
         r_empty  <= w_empty;
         r_done   <= w_done;
      end
   end

endmodule

// File: tb/tb_gol_engine.sv
// Directed bench for gol_engine: vector table of load+step cases over a
// bounded and a toroidal instance, plus hand sequences for run/halt/reset.
module tb_gol_engine;

   localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
   localparam logic [63:0] LONE    = 64'h0000_0000_0800_0000;
   localparam logic [63:0] EDGE3   = 64'h0000_0000_8300_0000;
   localparam logic [63:0] EDGE3_W = 64'h0000_0001_0101_0000;
   localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [63:0] seed;
   logic        start;
   logic        stop;
   logic        step;

   logic [63:0] grid0, grid1, grid2;
   logic [15:0] gen0, gen1, gen2;
   logic        run0, run1, run2;
   logic        stb0, stb1, stb2;
   logic        emp0, emp1, emp2;
   logic        dn0, dn1, dn2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gol_engine #(.PERIOD(1), .MAX_GEN(1000), .GEN_W(16), .WRAP(0)) dut0 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .start(start),
      .stop(stop), .step(step), .grid(grid0), .gen_count(gen0),
      .running(run0), .stable(stb0), .empty(emp0), .done(dn0));

   gol_engine #(.PERIOD(1), .MAX_GEN(1000), .GEN_W(16), .WRAP(1)) dut1 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .start(start),
      .stop(stop), .step(step), .grid(grid1), .gen_count(gen1),
      .running(run1), .stable(stb1), .empty(emp1), .done(dn1));

   gol_engine #(.PERIOD(3), .MAX_GEN(4), .GEN_W(16), .WRAP(0)) dut2 (
      .clk(clk), .reset(reset), .load(load), .seed(seed), .start(start),
      .stop(stop), .step(step), .grid(grid2), .gen_count(gen2),
      .running(run2), .stable(stb2), .empty(emp2), .done(dn2));

   typedef struct {
      string       name;
      logic [63:0] seed;
      int          steps;
      logic        wrap;
      logic [63:0] exp_grid;
      logic [15:0] exp_gen;
      logic        exp_stable;
      logic        exp_empty;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [63:0] s);
      seed = s;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; seed = '0; start = 1'b0; stop = 1'b0; step = 1'b0;

      vecs[0] = '{"blinker1",   BLINK_H, 1, 1'b0, BLINK_V, 16'd1, 1'b0, 1'b0};
      vecs[1] = '{"blinker2",   BLINK_H, 2, 1'b0, BLINK_H, 16'd2, 1'b0, 1'b0};
      vecs[2] = '{"block",      BLOCK,   3, 1'b0, BLOCK,   16'd1, 1'b1, 1'b0};
      vecs[3] = '{"lone",       LONE,    3, 1'b0, 64'h0,   16'd1, 1'b0, 1'b1};
      vecs[4] = '{"edge_nowrap", EDGE3,  1, 1'b0, 64'h0,   16'd1, 1'b0, 1'b1};
      vecs[5] = '{"edge_wrap",  EDGE3,   1, 1'b1, EDGE3_W, 16'd1, 1'b0, 1'b0};
      vecs[6] = '{"zero",       64'h0,   2, 1'b0, 64'h0,   16'd1, 1'b1, 1'b1};
      vecs[7] = '{"blinker5w",  BLINK_H, 5, 1'b1, BLINK_V, 16'd5, 1'b0, 1'b0};
      vecs[8] = '{"corners_w",  CORNERS, 2, 1'b1, CORNERS, 16'd1, 1'b1, 1'b0};

      tick();
      chk("rst_grid", grid0, 64'h0);
      chk("rst_gen", {48'h0, gen0}, 64'h0);
      chk("rst_flags", {60'h0, run0, stb0, emp0, dn0}, 64'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         do_load(vecs[i].seed);
         step = 1'b1;
         for (int k = 0; k < vecs[i].steps; k++) tick();
         step = 1'b0;
         tick();
         if (vecs[i].wrap) begin
            chk({vecs[i].name, "_grid"}, grid1, vecs[i].exp_grid);
            chk({vecs[i].name, "_gen"}, {48'h0, gen1}, {48'h0, vecs[i].exp_gen});
            chk({vecs[i].name, "_flags"}, {61'h0, stb1, emp1, dn1},
                {61'h0, vecs[i].exp_stable, vecs[i].exp_empty, 1'b0});
            chk({vecs[i].name, "_run"}, {63'h0, run1}, 64'h0);
         end else begin
            chk({vecs[i].name, "_grid"}, grid0, vecs[i].exp_grid);
            chk({vecs[i].name, "_gen"}, {48'h0, gen0}, {48'h0, vecs[i].exp_gen});
            chk({vecs[i].name, "_flags"}, {61'h0, stb0, emp0, dn0},
                {61'h0, vecs[i].exp_stable, vecs[i].exp_empty, 1'b0});
            chk({vecs[i].name, "_run"}, {63'h0, run0}, 64'h0);
         end
      end

      // Block under RUN: one update then HALT; start/step afterwards ignored.
      do_load(BLOCK);
      start = 1'b1; tick(); start = 1'b0;
      chk("blk_running", {63'h0, run0}, 64'h1);
      tick();
      chk("blk_halt_run", {63'h0, run0}, 64'h0);
      chk("blk_stable", {63'h0, stb0}, 64'h1);
      chk("blk_gen", {48'h0, gen0}, 64'd1);
      start = 1'b1; step = 1'b1;
      repeat (3) tick();
      start = 1'b0; step = 1'b0;
      chk("blk_ignored_gen", {48'h0, gen0}, 64'd1);
      chk("blk_ignored_run", {63'h0, run0}, 64'h0);

      // Generation limit with PERIOD=3, MAX_GEN=4 (dut2).
      do_load(BLINK_H);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("lim_gen_e2", {48'h0, gen2}, 64'd0);
      tick();
      chk("lim_gen_e3", {48'h0, gen2}, 64'd1);
      chk("lim_grid_e3", grid2, BLINK_V);
      repeat (8) tick();
      chk("lim_gen_e11", {48'h0, gen2}, 64'd3);
      chk("lim_run_e11", {63'h0, run2}, 64'h1);
      chk("lim_done_e11", {63'h0, dn2}, 64'h0);
      tick();
      chk("lim_gen_e12", {48'h0, gen2}, 64'd4);
      chk("lim_done_e12", {63'h0, dn2}, 64'h1);
      chk("lim_grid_e12", grid2, BLINK_H);
      chk("lim_run_e12", {63'h0, run2}, 64'h0);
      start = 1'b1; repeat (4) tick(); start = 1'b0;
      chk("lim_hold_gen", {48'h0, gen2}, 64'd4);

      // Stop during RUN (with step) freezes grid and gen_count.
      do_load(BLINK_H);
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      chk("run_gen5", {48'h0, gen0}, 64'd5);
      stop = 1'b1; step = 1'b1; tick(); stop = 1'b0; step = 1'b0;
      repeat (3) tick();
      chk("stop_gen", {48'h0, gen0}, 64'd5);
      chk("stop_grid", grid0, BLINK_V);
      chk("stop_run", {63'h0, run0}, 64'h0);

      // Load together with start stays IDLE.
      seed = BLINK_H; load = 1'b1; start = 1'b1;
      tick();
      load = 1'b0; start = 1'b0;
      chk("ldst_run", {63'h0, run0}, 64'h0);
      tick(); tick();
      chk("ldst_gen", {48'h0, gen0}, 64'd0);
      chk("ldst_grid", grid0, BLINK_H);

      // Asynchronous reset between edges while running.
      start = 1'b1; tick(); start = 1'b0;
      repeat (3) tick();
      #2 reset = 1'b1;
      #1;
      chk("arst_grid", grid0, 64'h0);
      chk("arst_gen", {48'h0, gen0}, 64'h0);
      chk("arst_flags", {60'h0, run0, stb0, emp0, dn0}, 64'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("arst_idle_gen", {48'h0, gen0}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
